// File: rtl/vrf_bank_arbiter_pkg.sv
// Shared types, sizes and helpers for the lane VRF bank arbiter.
package vrf_bank_arbiter_pkg;
    localparam int unsigned NrBanks   = 8;
    localparam int unsigned NrRdReq   = 4;
    localparam int unsigned NrWrReq   = 2;
    localparam int unsigned NrReq     = NrRdReq + NrWrReq;
    localparam int unsigned AddrWidth = 16;
    localparam int unsigned MaxStall  = 7;
    localparam int unsigned Elen      = 64;
    localparam int unsigned BankBits  = $clog2(NrBanks);
    localparam int unsigned RowWidth  = AddrWidth - BankBits;

    typedef logic [Elen-1:0]      elen_t;
    typedef logic [Elen/8-1:0]    strb_t;
    typedef logic [AddrWidth-1:0] vrf_addr_t;
    typedef logic [BankBits-1:0]  vrf_bank_t;
    typedef logic [RowWidth-1:0]  vrf_row_t;

    typedef enum logic [2:0] {
        ALU_A, ALU_B, MFPU_A, MFPU_B, MFPU_C, ST_A, SLDU_A, MASK_B
    } opqueue_e;

    typedef enum logic [1:0] {LutIdle, LutDrain, LutBcast} lut_state_e;

    // Banks are word-interleaved on the low address bits.
    function automatic vrf_bank_t vrf_bank_of(input vrf_addr_t addr);
        return addr[BankBits-1:0];
    endfunction
endpackage

// File: rtl/vrf_bank_arbiter_if.sv
// Requester/register-file bundle around the bank arbiter.
interface vrf_bank_arbiter_if;
    import vrf_bank_arbiter_pkg::*;

    logic [NrRdReq-1:0] rd_req;
    vrf_addr_t          rd_addr [NrRdReq];
    opqueue_e           rd_tgt  [NrRdReq];
    logic [NrRdReq-1:0] rd_gnt;
    logic [NrWrReq-1:0] wr_req;
    vrf_addr_t          wr_addr [NrWrReq];
    elen_t              wr_data [NrWrReq];
    strb_t              wr_be   [NrWrReq];
    logic [NrWrReq-1:0] wr_gnt;
    logic               lut_req;
    vrf_row_t           lut_row;
    logic               lut_gnt;
    logic               lut_busy;
    logic [NrBanks-1:0] vrf_req;
    vrf_addr_t          vrf_addr  [NrBanks];
    logic [NrBanks-1:0] vrf_wen;
    elen_t              vrf_wdata [NrBanks];
    strb_t              vrf_be    [NrBanks];
    opqueue_e           vrf_tgt   [NrBanks];

    modport master (
        output rd_req, rd_addr, rd_tgt, wr_req, wr_addr, wr_data, wr_be, lut_req, lut_row,
        input  rd_gnt, wr_gnt, lut_gnt, lut_busy,
        input  vrf_req, vrf_addr, vrf_wen, vrf_wdata, vrf_be, vrf_tgt
    );

    modport slave (
        input  rd_req, rd_addr, rd_tgt, wr_req, wr_addr, wr_data, wr_be, lut_req, lut_row,
        output rd_gnt, wr_gnt, lut_gnt, lut_busy,
        output vrf_req, vrf_addr, vrf_wen, vrf_wdata, vrf_be, vrf_tgt
    );
endinterface

// File: rtl/vrf_bank_prio_arb.sv
// One bank: boosted reads, then writes (lowest index), then round-robin reads.
module vrf_bank_prio_arb
    import vrf_bank_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NrReq-1:0]   req,
    input  logic [NrRdReq-1:0] boost,
    output logic [NrReq-1:0]   gnt
);
    localparam int unsigned PtrWidth = (NrRdReq > 1) ? $clog2(NrRdReq) : 1;
    typedef logic [PtrWidth-1:0] ptr_t;

    ptr_t               ptr_q, ptr_d;
    logic [NrRdReq-1:0] rd_req, boosted;
    logic [NrWrReq-1:0] wr_req;

    assign rd_req  = req[NrRdReq-1:0];
    assign wr_req  = req[NrReq-1:NrRdReq];
    assign boosted = rd_req & boost;

    function automatic logic [NrRdReq-1:0] rr_pick(input logic [NrRdReq-1:0] cand, input ptr_t ptr);
        logic [NrRdReq-1:0] pick;
        ptr_t               idx;
        pick = '0;
        for (int unsigned i = 0; i < NrRdReq; i++) begin
            idx = ptr_t'((32'(ptr) + i) % NrRdReq);
            if (cand[idx] && pick == '0) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it holding a value (latch).
        gnt   = '0;
        ptr_d = ptr_q;
        if (boosted != '0) begin
            gnt[NrRdReq-1:0] = rr_pick(boosted, ptr_q);
        end else if (wr_req != '0) begin
            gnt[NrReq-1:NrRdReq] = wr_req & (-wr_req);
        end else begin
            gnt[NrRdReq-1:0] = rr_pick(rd_req, ptr_q);
        end
        for (int unsigned i = 0; i < NrRdReq; i++) begin
            if (gnt[i]) ptr_d = ptr_t'((i + 1) % NrRdReq);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/vrf_bank_arbiter.sv
// Per-lane VRF bank scheduler: conflict resolution, read anti-starvation and the
// all-bank LUT broadcast sequence, with registered per-bank outputs.
module vrf_bank_arbiter
    import vrf_bank_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    vrf_bank_arbiter_if.slave  bus
);
    localparam int unsigned CntWidth = $clog2(MaxStall + 1);
    typedef logic [CntWidth-1:0] cnt_t;

    lut_state_e         state_q, state_d;
    logic               rd_en, wr_en, bcast, busy;
    cnt_t               stall_q [NrRdReq];
    logic [NrRdReq-1:0] boost, rd_gnt;
    logic [NrWrReq-1:0] wr_gnt;
    logic [NrReq-1:0]   bank_req [NrBanks];
    logic [NrReq-1:0]   bank_gnt [NrBanks];

    // Reads are held off from the cycle after a LUT request until the broadcast issues.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        bcast   = 1'b0;
        unique case (state_q)
            LutIdle:  if (bus.lut_req) state_d = LutDrain;
            LutDrain: begin
                rd_en   = 1'b0;
                state_d = LutBcast;
            end
            LutBcast: begin
                rd_en = 1'b0;
                if (bus.wr_req == '0) begin
                    bcast   = 1'b1;
                    wr_en   = 1'b0;
                    state_d = LutIdle;
                end
            end
            default: state_d = LutIdle;
        endcase
        if (rst) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
            bcast = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= LutIdle;
        else     state_q <= state_d;
    end

    assign busy         = (state_q != LutIdle);
    assign bus.lut_busy = busy;
    assign bus.lut_gnt  = bcast;

    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            bank_req[b] = '0;
            for (int r = 0; r < NrRdReq; r++)
                bank_req[b][r] = rd_en && bus.rd_req[r] && (vrf_bank_of(bus.rd_addr[r]) == vrf_bank_t'(b));
            for (int w = 0; w < NrWrReq; w++)
                bank_req[b][NrRdReq+w] = wr_en && bus.wr_req[w] && (vrf_bank_of(bus.wr_addr[w]) == vrf_bank_t'(b));
        end
        for (int r = 0; r < NrRdReq; r++) boost[r] = (stall_q[r] == cnt_t'(MaxStall));
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        vrf_bank_prio_arb u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (bank_req[b]),
            .boost (boost),
            .gnt   (bank_gnt[b])
        );
    end

    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        for (int b = 0; b < NrBanks; b++) begin
            rd_gnt |= bank_gnt[b][NrRdReq-1:0];
            wr_gnt |= bank_gnt[b][NrReq-1:NrRdReq];
        end
    end

    assign bus.rd_gnt = rd_gnt;
    assign bus.wr_gnt = wr_gnt;

    // Counters saturate at MaxStall and hold still while the LUT sequence owns the banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NrRdReq; r++) stall_q[r] <= '0;
        end else if (!busy) begin
            for (int r = 0; r < NrRdReq; r++) begin
                if (!bus.rd_req[r] || rd_gnt[r])        stall_q[r] <= '0;
                else if (stall_q[r] != cnt_t'(MaxStall)) stall_q[r] <= stall_q[r] + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: these per-bank register arrays are reset because they drive the register file directly and must read 0 out of reset.
        if (rst) begin
            for (int b = 0; b < NrBanks; b++) begin
                bus.vrf_req[b]   <= 1'b0;
                bus.vrf_wen[b]   <= 1'b0;
                bus.vrf_addr[b]  <= '0;
                bus.vrf_wdata[b] <= '0;
                bus.vrf_be[b]    <= '0;
                bus.vrf_tgt[b]   <= ALU_A;
            end
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                bus.vrf_req[b]   <= bcast || (bank_gnt[b] != '0);
                bus.vrf_wen[b]   <= 1'b0;
                bus.vrf_addr[b]  <= bcast ? {bus.lut_row, vrf_bank_t'(b)} : '0;
                bus.vrf_wdata[b] <= '0;
                bus.vrf_be[b]    <= '0;
                bus.vrf_tgt[b]   <= ALU_A;
                for (int r = 0; r < NrRdReq; r++) begin
                    if (bank_gnt[b][r]) begin
                        bus.vrf_addr[b] <= bus.rd_addr[r];
                        bus.vrf_tgt[b]  <= bus.rd_tgt[r];
                    end
                end
                for (int w = 0; w < NrWrReq; w++) begin
                    if (bank_gnt[b][NrRdReq+w]) begin
                        bus.vrf_wen[b]   <= 1'b1;
                        bus.vrf_addr[b]  <= bus.wr_addr[w];
                        bus.vrf_wdata[b] <= bus.wr_data[w];
                        bus.vrf_be[b]    <= bus.wr_be[w];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Directed bench for vrf_bank_arbiter with hand-computed expectations.
module tb_vrf_bank_arbiter;
    import vrf_bank_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vrf_bank_arbiter_if bus ();

    vrf_bank_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd_req  = '0;
        bus.wr_req  = '0;
        bus.lut_req = 1'b0;
        bus.lut_row = '0;
        for (int r = 0; r < NrRdReq; r++) begin
            bus.rd_addr[r] = '0;
            bus.rd_tgt[r]  = ALU_A;
        end
        for (int w = 0; w < NrWrReq; w++) begin
            bus.wr_addr[w] = '0;
            bus.wr_data[w] = '0;
            bus.wr_be[w]   = '0;
        end
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // A requester that was pending without a grant must still be requesting.
    logic [NrRdReq-1:0] pend_rd;
    logic [NrWrReq-1:0] pend_wr;
    always @(negedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NrRdReq; r++) if (pend_rd[r]) check("hold_rd", bus.rd_req[r], 1);
            for (int w = 0; w < NrWrReq; w++) if (pend_wr[w]) check("hold_wr", bus.wr_req[w], 1);
        end
        pend_rd <= rst ? '0 : (bus.rd_req & ~bus.rd_gnt);
        pend_wr <= rst ? '0 : (bus.wr_req & ~bus.wr_gnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g;
        idle_inputs();

        // Reset with every requester active.
        bus.rd_req = 4'hF;
        for (int r = 0; r < NrRdReq; r++) bus.rd_addr[r] = vrf_addr_t'(r);
        bus.rd_tgt[2]  = MFPU_C;
        bus.wr_req     = 2'b11;
        bus.wr_addr[0] = 16'h0004;
        bus.wr_addr[1] = 16'h0005;
        bus.wr_data[1] = 64'hCAFE;
        bus.wr_be[1]   = 8'hF0;
        sample();
        check("rst_vrf_req", bus.vrf_req, 0);
        check("rst_vrf_addr0", bus.vrf_addr[0], 0);
        check("rst_rd_gnt", bus.rd_gnt, 0);
        check("rst_wr_gnt", bus.wr_gnt, 0);
        check("rst_busy", bus.lut_busy, 0);
        step();
        rst = 1'b0;
        sample();
        check("rel_rd_gnt", bus.rd_gnt, 4'hF);
        check("rel_wr_gnt", bus.wr_gnt, 2'b11);
        check("rel_vrf_req", bus.vrf_req, 0);
        step();
        idle_inputs();
        sample();
        check("rel_vrf_req1", bus.vrf_req, 8'h3F);
        check("rel_vrf_wen1", bus.vrf_wen, 8'h30);
        check("rel_addr5", bus.vrf_addr[5], 16'h0005);
        check("rel_wdata5", bus.vrf_wdata[5], 64'hCAFE);
        check("rel_be5", bus.vrf_be[5], 8'hF0);
        check("rel_tgt2", bus.vrf_tgt[2], MFPU_C);

        // Two reads on bank 0 alternate.
        reset_dut();
        bus.rd_req     = 4'b0011;
        bus.rd_addr[0] = 16'h0010;
        bus.rd_addr[1] = 16'h0018;
        bus.rd_tgt[0]  = ALU_B;
        bus.rd_tgt[1]  = MFPU_A;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            sample();
            check("rr_gnt", bus.rd_gnt, (i % 2 == 0) ? 1 : 2);
            if (i > 0) begin
                check("rr_vrf_req", bus.vrf_req, 8'h01);
                check("rr_addr0", bus.vrf_addr[0], (i % 2 == 1) ? 16'h0010 : 16'h0018);
                check("rr_tgt0", bus.vrf_tgt[0], (i % 2 == 1) ? ALU_B : MFPU_A);
            end
        end

        // Write hogging bank 3 until rd2 is boosted, twice.
        reset_dut();
        bus.wr_req     = 2'b01;
        bus.wr_addr[0] = 16'h0003;
        bus.wr_data[0] = 64'h1234;
        bus.wr_be[0]   = 8'hFF;
        bus.rd_req     = 4'b0100;
        bus.rd_addr[2] = 16'h000B;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            sample();
            g = (i == 7) || (i == 15);
            check("stall_rd_gnt", bus.rd_gnt, g ? 4'b0100 : 4'b0000);
            check("stall_wr_gnt", bus.wr_gnt, g ? 2'b00 : 2'b01);
            if (i > 0) check("stall_wen", bus.vrf_wen, (i == 8) ? 8'h00 : 8'h08);
        end
        step();
        sample();
        check("stall_addr3", bus.vrf_addr[3], 16'h000B);
        check("stall_wen_last", bus.vrf_wen, 8'h00);

        // Writes beat normal reads on banks 1 and 2; reads go next cycle.
        reset_dut();
        bus.rd_req     = 4'b0011;
        bus.rd_addr[0] = 16'h0001;
        bus.rd_addr[1] = 16'h0002;
        bus.wr_req     = 2'b11;
        bus.wr_addr[0] = 16'h0009;
        bus.wr_addr[1] = 16'h000A;
        sample();
        check("conf_rd_gnt", bus.rd_gnt, 0);
        check("conf_wr_gnt", bus.wr_gnt, 2'b11);
        step();
        bus.wr_req = '0;
        sample();
        check("conf_rd_gnt1", bus.rd_gnt, 4'b0011);
        check("conf_vrf_req1", bus.vrf_req, 8'h06);
        check("conf_wen1", bus.vrf_wen, 8'h06);
        step();
        bus.rd_req = '0;
        sample();
        check("conf_vrf_req2", bus.vrf_req, 8'h06);
        check("conf_wen2", bus.vrf_wen, 8'h00);
        check("conf_addr1", bus.vrf_addr[1], 16'h0001);
        check("conf_addr2", bus.vrf_addr[2], 16'h0002);

        // LUT broadcast from idle, with a read arriving during the drain.
        reset_dut();
        bus.lut_req = 1'b1;
        bus.lut_row = RowWidth'(5);
        sample();
        check("lut_busy0", bus.lut_busy, 0);
        check("lut_gnt0", bus.lut_gnt, 0);
        step();
        bus.rd_req     = 4'b1000;
        bus.rd_addr[3] = 16'h000C;
        sample();
        check("lut_busy1", bus.lut_busy, 1);
        check("lut_gnt1", bus.lut_gnt, 0);
        check("lut_rd_blk1", bus.rd_gnt, 0);
        step();
        sample();
        check("lut_gnt2", bus.lut_gnt, 1);
        check("lut_rd_blk2", bus.rd_gnt, 0);
        step();
        bus.lut_req = 1'b0;
        sample();
        check("lut_vrf_req", bus.vrf_req, 8'hFF);
        check("lut_wen", bus.vrf_wen, 8'h00);
        check("lut_tgt3", bus.vrf_tgt[3], ALU_A);
        for (int b = 0; b < NrBanks; b++) check("lut_addr", bus.vrf_addr[b], 5 * 8 + b);
        check("lut_busy3", bus.lut_busy, 0);
        check("lut_rd_after", bus.rd_gnt, 4'b1000);
        step();
        bus.rd_req = '0;
        sample();
        check("lut_rd_req", bus.vrf_req, 8'h10);
        check("lut_rd_addr4", bus.vrf_addr[4], 16'h000C);

        // Pending write holds the FSM in BCAST.
        reset_dut();
        bus.wr_req     = 2'b01;
        bus.wr_addr[0] = 16'h0021;
        bus.lut_req    = 1'b1;
        bus.lut_row    = RowWidth'(2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            sample();
            check("hold_lut_gnt", bus.lut_gnt, 0);
            check("hold_wr_gnt", bus.wr_gnt, 2'b01);
        end
        step();
        bus.wr_req = '0;
        sample();
        check("hold_lut_gnt4", bus.lut_gnt, 1);
        check("hold_wr_gnt4", bus.wr_gnt, 0);
        check("hold_wen4", bus.vrf_wen, 8'h02);
        step();
        bus.lut_req = 1'b0;
        sample();
        check("hold_bc_req", bus.vrf_req, 8'hFF);
        check("hold_bc_addr7", bus.vrf_addr[7], 2 * 8 + 7);

        // Reset while sitting in BCAST drops the broadcast.
        reset_dut();
        bus.wr_req     = 2'b01;
        bus.wr_addr[0] = 16'h0021;
        bus.lut_req    = 1'b1;
        bus.lut_row    = RowWidth'(3);
        sample();
        step();
        sample();
        step();
        sample();
        check("mid_lut_gnt", bus.lut_gnt, 0);
        step();
        rst        = 1'b1;
        bus.wr_req = '0;
        sample();
        check("mid_rst_lut_gnt", bus.lut_gnt, 0);
        check("mid_rst_wr_gnt", bus.wr_gnt, 0);
        check("mid_rst_rd_gnt", bus.rd_gnt, 0);
        step();
        rst         = 1'b0;
        bus.lut_req = 1'b0;
        sample();
        check("mid_vrf_req", bus.vrf_req, 0);
        check("mid_vrf_wen", bus.vrf_wen, 0);
        check("mid_busy", bus.lut_busy, 0);
        check("mid_lut_gnt2", bus.lut_gnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vrf_bank_arbiter.md
Name: vrf_bank_arbiter

Overview:
Per-lane scheduler that shares the NrBanks single-ported VRF SRAM banks between operand read requesters and writeback requesters. It resolves per-bank conflicts, prevents read starvation, and sequences the all-bank LUT broadcast read. Its registered outputs drive the lane register file's per-bank request/address/write/target interface directly.

Parameters:
NrBanks, 8, number of VRF banks (power of two, ≥2)
NrRdReq, 4, number of operand read requesters
NrWrReq, 2, number of writeback requesters
AddrWidth, 16, width of a lane VRF word address
MaxStall, 7, consecutive denied cycles before a read requester is boosted above writes (≥1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
rd_req_i  in  NrRdReq  read request valid
rd_addr_i  in  NrRdReq×AddrWidth  read word address
rd_tgt_i  in  NrRdReq×opqueue_e  target operand queue
rd_gnt_o  out  NrRdReq  read granted this cycle
wr_req_i  in  NrWrReq  write request valid
wr_addr_i  in  NrWrReq×AddrWidth  write word address
wr_data_i  in  NrWrReq×elen_t  write data
wr_be_i  in  NrWrReq×strb_t  byte enables
wr_gnt_o  out  NrWrReq  write granted this cycle
lut_req_i  in  1  LUT broadcast read request
lut_row_i  in  AddrWidth-log2(NrBanks)  row read from every bank
lut_gnt_o  out  1  broadcast issued this cycle
lut_busy_o  out  1  LUT FSM not IDLE
vrf_req_o  out  NrBanks  bank request (registered)
vrf_addr_o  out  NrBanks×AddrWidth  bank word address (registered)
vrf_wen_o  out  NrBanks  bank write enable (registered)
vrf_wdata_o  out  NrBanks×elen_t  bank write data (registered)
vrf_be_o  out  NrBanks×strb_t  bank byte enables (registered)
vrf_tgt_o  out  NrBanks×opqueue_e  read target queue (registered)

Behaviour:
- Reset: all vrf_* outputs 0; grants 0; round-robin pointers 0; stall counters 0; LUT FSM in IDLE; lut_busy_o 0.
- Bank select: bank = addr[log2(NrBanks)-1:0]. vrf_addr_o is passed through unchanged.
- Grants are combinational in cycle N. The matching bank request appears on vrf_* in cycle N+1. Each bank receives at most one grant per cycle.
- A requester holds req, addr, data and be stable until it sees gnt. Withdrawing a request without a grant is illegal, and the bench asserts on it.
- Per-bank priority, highest first:
  1. boosted reads
  2. writes (lowest index wins)
  3. normal reads (round-robin)
- Round-robin: each bank has its own read pointer. On a read grant in that bank, the pointer advances to grantee+1 mod NrRdReq.
- Starvation: each read requester has a stall counter.
  - The counter increments while req=1 and gnt=0; it resets to 0 on grant or when req=0.
  - At count == MaxStall the requester is boosted.
  - Among multiple boosted requesters on one bank, the round-robin order decides.
- LUT FSM:
  - IDLE: on lut_req_i, go to DRAIN. Normal arbitration continues this cycle.
  - DRAIN: grant no reads (rd_gnt_o = 0). Writes may still be granted. Go to BCAST.
  - BCAST: requires no write request pending to any bank.
    - If the condition holds: assert lut_gnt_o, grant nothing else, register vrf_req_o = all 1, wen = 0, addr = {lut_row_i, bank}, tgt = 0. Go to IDLE.
    - Otherwise stay in BCAST with writes granted. Reads stay blocked.
- Because of the above, the register file sees either a full all-bank read cycle or a non-all-bank pattern, never a partial broadcast.
- Stall counters freeze while lut_busy_o = 1.
- Simultaneous write and boosted read to the same bank: the read wins, and the write's grant is deferred.
- rst_i asserted mid-operation: all state and outputs clear on the next edge. An in-flight BCAST is dropped with no lut_gnt_o.
- lut_req_i is held until lut_gnt_o.

Decomposition:
- ara_pkg gains vrf_bank_t (logic [log2(NrBanks)-1:0]) and a function vrf_bank_of(addr).
- elen_t, strb_t and opqueue_e are reused from ara_pkg.
- One sub-module, vrf_bank_prio_arb: per-bank priority plus round-robin arbiter with an NrRdReq+NrWrReq request vector and a boost vector. It is instantiated NrBanks times.

Test Plan:
- Reset with all requests high → all vrf_* = 0 during reset; after release the first grants appear and vrf_req_o rises exactly one cycle later.
- rd0 to addr 0x10 and rd1 to addr 0x18 (both bank 0), continuously → grants alternate rd0, rd1, rd0…; vrf_addr_o[0] follows with 1-cycle lag.
- wr0 continuously to bank 3 and rd2 to bank 3 → rd2 is denied 7 cycles, then granted on cycle 8 (MaxStall=7); wr0 is denied that cycle; the counter then returns to 0.
- rd0 to bank 1, rd1 to bank 2, wr0 to bank 1, wr1 to bank 2, all in one cycle → rd_gnt_o = 0, wr_gnt_o = 2'b11; the next cycle issues the reads.
- lut_req_i with lut_row_i = 5 while idle → DRAIN, then BCAST; lut_gnt_o in cycle 2; the following cycle vrf_req_o = 8'hFF and vrf_addr_o[b] = 5*8+b.
- lut_req_i with wr0 pending → FSM holds in BCAST until the write is granted, then broadcasts; rst_i during BCAST → no lut_gnt_o, all outputs 0.
